// File: rtl/flush_sequencer.sv
// Branch-mispredict recovery: unwinds the active list youngest-first, freeing and restoring mappings.
// Optional FLUSH_SEQ_PERF_EN adds saturating flush-count and flush-cycle performance counters.
module flush_sequencer #(
    parameter int AL_DEPTH = 32,
    parameter int IDX_W    = 5,
    parameter int PREG_W   = 6,
    parameter int ID_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mispredict_valid,
    input  logic [IDX_W-1:0]  mispredict_al_idx,
    input  logic [ID_W-1:0]   mispredict_id,
    input  logic [IDX_W-1:0]  al_head,
    input  logic [IDX_W-1:0]  al_tail,
    output logic [IDX_W-1:0]  al_rd_idx,
    input  logic              al_rd_uses_rw,
    input  logic [4:0]        al_rd_arch,
    input  logic [PREG_W-1:0] al_rd_old_preg,
    input  logic [PREG_W-1:0] al_rd_new_preg,
    output logic              fl_release_valid,
    output logic [PREG_W-1:0] fl_release_preg,
    output logic              rmt_restore_valid,
    output logic [4:0]        rmt_restore_arch,
    output logic [PREG_W-1:0] rmt_restore_preg,
    output logic              flush,
    output logic [ID_W-1:0]   flushed_instruction_ID,
    output logic              al_tail_set_valid,
    output logic [IDX_W-1:0]  al_tail_set,
    output logic              flush_done,
`ifdef FLUSH_SEQ_PERF_EN
    output logic [15:0]       perf_flush_count,
    output logic [31:0]       perf_flush_cycles,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   REM_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t            state;
    logic [IDX_W-1:0]  br_idx;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W:0]    remaining;
    logic [ID_W-1:0]   br_id;

    logic [IDX_W-1:0]  new_age;
    logic [IDX_W-1:0]  br_age;
    logic              older;
    logic [IDX_W-1:0]  first_rem;
    logic [IDX_W-1:0]  retarget_rem;
    logic [IDX_W:0]    cur_rem;
    logic              walking;
    logic              finishing;

    // Ages relative to the head make the older/younger decision wrap-safe.
    assign new_age      = mispredict_al_idx - al_head;
    assign br_age       = br_idx - al_head;
    assign older        = mispredict_valid && (new_age < br_age);
    assign first_rem    = al_tail - mispredict_al_idx - ONE;
    assign retarget_rem = ptr - mispredict_al_idx;
    assign cur_rem      = older ? {1'b0, retarget_rem} : remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            br_idx    <= '0;
            ptr       <= '0;
            remaining <= '0;
            br_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict_valid) begin
                        br_idx    <= mispredict_al_idx;
                        br_id     <= mispredict_id;
                        ptr       <= al_tail - ONE;
                        remaining <= {1'b0, first_rem};
                        state     <= (first_rem != '0) ? WALK : DONE;
                    end
                end
                WALK: begin
                    if (older) begin
                        br_idx <= mispredict_al_idx;
                        br_id  <= mispredict_id;
                    end
                    ptr       <= ptr - ONE;
                    remaining <= cur_rem - REM_ONE;
                    state     <= (cur_rem == REM_ONE) ? DONE : WALK;
                end
                DONE: begin
                    // ptr already sits on the old branch, which an older mispredict must also squash.
                    if (older) begin
                        br_idx    <= mispredict_al_idx;
                        br_id     <= mispredict_id;
                        remaining <= {1'b0, retarget_rem};
                        state     <= WALK;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign walking   = (state == WALK);
    assign finishing = (state == DONE) && !older;

    assign al_rd_idx              = walking ? ptr : '0;
    assign fl_release_valid       = walking && al_rd_uses_rw;
    assign rmt_restore_valid      = walking && al_rd_uses_rw;
    assign fl_release_preg        = walking ? al_rd_new_preg : '0;
    assign rmt_restore_arch       = walking ? al_rd_arch : '0;
    assign rmt_restore_preg       = walking ? al_rd_old_preg : '0;
    assign flush                  = (state != IDLE);
    assign busy                   = (state != IDLE);
    assign flushed_instruction_ID = flush ? br_id : '0;
    assign al_tail_set_valid      = finishing;
    assign al_tail_set            = finishing ? (br_idx + ONE) : '0;
    assign flush_done             = finishing;

`ifdef FLUSH_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_flush_count  <= '0;
            perf_flush_cycles <= '0;
        end else begin
            if (flush_done && (perf_flush_count != '1))
                perf_flush_count <= perf_flush_count + 16'd1;
            if (flush && (perf_flush_cycles != '1))
                perf_flush_cycles <= perf_flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_flush_sequencer.sv
// Self-checking bench for flush_sequencer: directed scenarios plus randomized flushes
// compared against a slot-list model of which entries must be unwound on which cycle.
module tb_flush_sequencer;

    localparam int AL_DEPTH = 32;
    localparam int IDX_W    = 5;
    localparam int PREG_W   = 6;
    localparam int ID_W     = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mispredict_valid;
    logic [IDX_W-1:0]  mispredict_al_idx;
    logic [ID_W-1:0]   mispredict_id;
    logic [IDX_W-1:0]  al_head;
    logic [IDX_W-1:0]  al_tail;
    logic [IDX_W-1:0]  al_rd_idx;
    logic              al_rd_uses_rw;
    logic [4:0]        al_rd_arch;
    logic [PREG_W-1:0] al_rd_old_preg;
    logic [PREG_W-1:0] al_rd_new_preg;
    logic              fl_release_valid;
    logic [PREG_W-1:0] fl_release_preg;
    logic              rmt_restore_valid;
    logic [4:0]        rmt_restore_arch;
    logic [PREG_W-1:0] rmt_restore_preg;
    logic              flush;
    logic [ID_W-1:0]   flushed_instruction_ID;
    logic              al_tail_set_valid;
    logic [IDX_W-1:0]  al_tail_set;
    logic              flush_done;
    logic              busy;

    logic              mem_uses [AL_DEPTH];
    logic [4:0]        mem_arch [AL_DEPTH];
    logic [PREG_W-1:0] mem_old  [AL_DEPTH];
    logic [PREG_W-1:0] mem_new  [AL_DEPTH];

    logic [64:0] all_out;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign al_rd_uses_rw  = mem_uses[al_rd_idx];
    assign al_rd_arch     = mem_arch[al_rd_idx];
    assign al_rd_old_preg = mem_old[al_rd_idx];
    assign al_rd_new_preg = mem_new[al_rd_idx];

    assign all_out = {al_rd_idx, fl_release_valid, fl_release_preg, rmt_restore_valid,
                      rmt_restore_arch, rmt_restore_preg, flush, flushed_instruction_ID,
                      al_tail_set_valid, al_tail_set, flush_done, busy};

    flush_sequencer #(
        .AL_DEPTH(AL_DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W), .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mispredict_valid(mispredict_valid),
        .mispredict_al_idx(mispredict_al_idx),
        .mispredict_id(mispredict_id),
        .al_head(al_head),
        .al_tail(al_tail),
        .al_rd_idx(al_rd_idx),
        .al_rd_uses_rw(al_rd_uses_rw),
        .al_rd_arch(al_rd_arch),
        .al_rd_old_preg(al_rd_old_preg),
        .al_rd_new_preg(al_rd_new_preg),
        .fl_release_valid(fl_release_valid),
        .fl_release_preg(fl_release_preg),
        .rmt_restore_valid(rmt_restore_valid),
        .rmt_restore_arch(rmt_restore_arch),
        .rmt_restore_preg(rmt_restore_preg),
        .flush(flush),
        .flushed_instruction_ID(flushed_instruction_ID),
        .al_tail_set_valid(al_tail_set_valid),
        .al_tail_set(al_tail_set),
        .flush_done(flush_done),
        .busy(busy)
    );

    // mode 0: all entries write a register, 1: alternating, 2: random
    task automatic fill_mem(input int mode);
        for (int i = 0; i < AL_DEPTH; i++) begin
            if (mode == 0)      mem_uses[i] = 1'b1;
            else if (mode == 1) mem_uses[i] = i[0];
            else                mem_uses[i] = 1'($urandom_range(0, 1));
            mem_arch[i] = 5'($urandom);
            mem_old[i]  = 6'($urandom);
            mem_new[i]  = 6'($urandom);
        end
    endtask

    // Drives one flush (optionally with a second mispredict k cycles after the first) and
    // checks every cycle against the list of slots the model says must be unwound.
    task automatic run_walk(input logic [4:0] head, input logic [4:0] tail,
                            input logic [4:0] idx1, input logic [31:0] id1,
                            input int k, input logic [4:0] idx2, input logic [31:0] id2);
        logic [4:0]  age1, age2, final_br, nn, nn1, slot;
        logic [31:0] exp_id;
        bit          older, bubble;
        int          n, n1, last, eff;
        age1     = idx1 - head;
        age2     = idx2 - head;
        older    = (k != 0) && (age2 < age1);
        final_br = older ? idx2 : idx1;
        nn       = tail - final_br - 5'd1;
        nn1      = tail - idx1 - 5'd1;
        n        = int'(nn);
        n1       = int'(nn1);
        bubble   = older && (k == n1 + 1);
        last     = n + 1 + (bubble ? 1 : 0);

        @(negedge clk);
        al_head = head;
        al_tail = tail;
        mispredict_valid  = 1'b1;
        mispredict_al_idx = idx1;
        mispredict_id     = id1;
        @(posedge clk);
        #1 mispredict_valid = 1'b0;

        for (int c = 1; c <= last; c++) begin
            if (c == k) begin
                mispredict_valid  = 1'b1;
                mispredict_al_idx = idx2;
                mispredict_id     = id2;
            end
            @(negedge clk);
            exp_id = (older && c > k) ? id2 : id1;
            eff    = (bubble && c > k) ? c - 1 : c;
            slot   = tail - 5'(eff);
            checks++;
            if (flush !== 1'b1 || busy !== 1'b1) begin
                fails++;
                $display("[TB] FAIL flush_busy c=%0d got flush=%b busy=%b exp 1 1", c, flush, busy);
            end
            checks++;
            if (flushed_instruction_ID !== exp_id) begin
                fails++;
                $display("[TB] FAIL flush_id c=%0d got %h exp %h", c, flushed_instruction_ID, exp_id);
            end
            if (bubble && c == k) begin
                checks++;
                if (fl_release_valid !== 1'b0 || flush_done !== 1'b0 || al_tail_set_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL retarget_bubble c=%0d got rel=%b done=%b tsv=%b exp 0 0 0",
                             c, fl_release_valid, flush_done, al_tail_set_valid);
                end
            end else if (eff <= n) begin
                checks++;
                if (al_rd_idx !== slot) begin
                    fails++;
                    $display("[TB] FAIL rd_idx c=%0d got %0d exp %0d", c, al_rd_idx, slot);
                end
                checks++;
                if (fl_release_valid !== mem_uses[slot] || rmt_restore_valid !== mem_uses[slot]) begin
                    fails++;
                    $display("[TB] FAIL release_valid c=%0d got rel=%b rst=%b exp %b",
                             c, fl_release_valid, rmt_restore_valid, mem_uses[slot]);
                end
                if (mem_uses[slot]) begin
                    checks++;
                    if (fl_release_preg !== mem_new[slot] || rmt_restore_arch !== mem_arch[slot] ||
                        rmt_restore_preg !== mem_old[slot]) begin
                        fails++;
                        $display("[TB] FAIL restore_data c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c,
                                 fl_release_preg, rmt_restore_arch, rmt_restore_preg,
                                 mem_new[slot], mem_arch[slot], mem_old[slot]);
                    end
                end
                checks++;
                if (flush_done !== 1'b0 || al_tail_set_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL early_done c=%0d got done=%b tsv=%b exp 0 0",
                             c, flush_done, al_tail_set_valid);
                end
            end else begin
                checks++;
                if (flush_done !== 1'b1 || al_tail_set_valid !== 1'b1 ||
                    al_tail_set !== final_br + 5'd1 || fl_release_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL done_cycle c=%0d got done=%b tsv=%b ts=%0d rel=%b exp 1 1 %0d 0",
                             c, flush_done, al_tail_set_valid, al_tail_set, fl_release_valid,
                             final_br + 5'd1);
                end
            end
            @(posedge clk);
            #1 mispredict_valid = 1'b0;
        end

        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0 || fl_release_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL back_to_idle got flush=%b busy=%b done=%b rel=%b exp 0 0 0 0",
                     flush, busy, flush_done, fl_release_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mispredict_valid  = 1'b0;
        mispredict_al_idx = '0;
        mispredict_id     = '0;
        al_head = '0;
        al_tail = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_out !== 65'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got %h exp 0", all_out);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic_walk();
        fill_mem(0);
        run_walk(5'd0, 5'd5, 5'd1, 32'h40, 0, 5'd0, 32'h0);
    endtask

    task automatic test_full_list_wrap();
        fill_mem(2);
        run_walk(5'd3, 5'd3, 5'd3, 32'h1234, 0, 5'd0, 32'h0);
    endtask

    task automatic test_zero_remaining();
        fill_mem(0);
        run_walk(5'd0, 5'd9, 5'd8, 32'h77, 0, 5'd0, 32'h0);
    endtask

    task automatic test_retarget();
        fill_mem(2);
        run_walk(5'd0, 5'd14, 5'd3, 32'hA1, 4, 5'd1, 32'hB2);
        run_walk(5'd0, 5'd14, 5'd3, 32'hA1, 5, 5'd7, 32'hC3);
        run_walk(5'd0, 5'd6, 5'd3, 32'hD4, 3, 5'd1, 32'hE5);
        run_walk(5'd28, 5'd6, 5'd2, 32'hF6, 2, 5'd30, 32'h17);
    endtask

    task automatic test_sparse_uses();
        fill_mem(1);
        run_walk(5'd10, 5'd20, 5'd11, 32'h99, 0, 5'd0, 32'h0);
    endtask

    task automatic test_reset_mid_walk();
        fill_mem(0);
        @(negedge clk);
        al_head = 5'd0;
        al_tail = 5'd20;
        mispredict_valid  = 1'b1;
        mispredict_al_idx = 5'd2;
        mispredict_id     = 32'h5A5A;
        @(posedge clk);
        #1 mispredict_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out !== 65'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_walk got %h exp 0", all_out);
        end
        run_walk(5'd0, 5'd8, 5'd4, 32'h6B6B, 0, 5'd0, 32'h0);
    endtask

    task automatic test_random();
        logic [4:0]  head, tail, idx1, idx2;
        logic [31:0] id1, id2;
        int          count, age1, age2, n1, k;
        for (int it = 0; it < 25; it++) begin
            fill_mem(2);
            head  = 5'($urandom);
            count = $urandom_range(1, 32);
            tail  = head + 5'(count);
            age1  = $urandom_range(0, count - 1);
            idx1  = head + 5'(age1);
            id1   = $urandom;
            id2   = $urandom;
            n1    = int'(5'(tail - idx1 - 5'd1));
            age2  = $urandom_range(0, count - 1);
            idx2  = head + 5'(age2);
            k     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n1 + 1) : 0;
            run_walk(head, tail, idx1, id1, k, idx2, id2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_walk();
        test_full_list_wrap();
        test_zero_remaining();
        test_retarget();
        test_sparse_uses();
        test_reset_mid_walk();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
